proc_ctrl_seq: RTL and testbench

//  Multi-cycle control unit for the shared-bus register datapath (R0..R(NREG-1), A, G, add/sub ALU).

---
 rtl/proc_ctrl_seq.sv | 169 ++++++++++++++++
 tb/tb_proc_ctrl_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_seq.sv
// ============================================================================
// proc_ctrl_seq : multi-cycle bus/ALU control sequencer with one-deep
//                 instruction buffer. Optional macro XOR_OP_EN adds func 100 = xor.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module proc_ctrl_seq #(
  parameter int RW = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3+2*RW-1:0]     instr,
  output logic [(2**RW)+1:0]    bus_out_en,
  output logic [(2**RW)+1:0]    bus_in_en,
  output logic                  alu_sub,
  output logic                  alu_xor,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal
);

  localparam int c_NREG = 2**RW;
  localparam int c_IW   = 3 + 2*RW;
  localparam int c_BW   = c_NREG + 2;
  localparam int c_DIN  = c_NREG + 1;   // DINout / Ain position
  localparam int c_G    = c_NREG;       // Gout / Gin position

  localparam logic [2:0] c_MVI = 3'b000;
  localparam logic [2:0] c_MV  = 3'b001;
  localparam logic [2:0] c_ADD = 3'b010;
  localparam logic [2:0] c_SUB = 3'b011;
`ifdef XOR_OP_EN
  localparam logic [2:0] c_XOR = 3'b100;
`endif

  localparam logic [c_BW-1:0] c_ONE = c_BW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            w_after_final;
  logic [c_IW-1:0]   r_ir;
  logic [c_IW-1:0]   r_pend;
  logic              r_pend_valid;

  logic [2:0]        w_func;
  logic [RW-1:0]     w_rx;
  logic [RW-1:0]     w_ry;
  logic [c_BW-1:0]   w_rx_dec;
  logic [c_BW-1:0]   w_ry_dec;
  logic              w_is_alu;
  logic              w_final;
  logic              w_xfer;
  logic              w_to_ir;

  assign w_func   = r_ir[c_IW-1 -: 3];
  assign w_rx     = r_ir[2*RW-1:RW];
  assign w_ry     = r_ir[RW-1:0];
  assign w_rx_dec = c_ONE << w_rx;
  assign w_ry_dec = c_ONE << w_ry;

`ifdef XOR_OP_EN
  assign w_is_alu = (w_func == c_ADD) || (w_func == c_SUB) || (w_func == c_XOR);
`else
  assign w_is_alu = (w_func == c_ADD) || (w_func == c_SUB);
`endif

  assign w_final     = ((r_state == S_T1) && !w_is_alu) || (r_state == S_T3);
  assign instr_ready = !r_pend_valid;
  assign w_xfer      = instr_valid && !r_pend_valid;
  // A new word goes straight to IR only when IR is free at this edge.
  assign w_to_ir     = (r_state == S_IDLE) || (w_final && !r_pend_valid);
  assign w_after_final = (r_pend_valid || w_xfer) ? S_T1 : S_IDLE;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ir         <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_xfer && w_to_ir) begin
        r_ir <= instr;
      end else if (w_final && r_pend_valid) begin
        r_ir <= r_pend;
      end

      if (w_xfer && !w_to_ir) begin
        r_pend       <= instr;
        r_pend_valid <= 1'b1;
      end else if (w_final && r_pend_valid) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus_out_en  = '0;
    bus_in_en   = '0;
    alu_sub     = 1'b0;
    alu_xor     = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = w_xfer ? S_T1 : S_IDLE;
      end
      S_T1: begin
        if (w_is_alu) begin
          bus_out_en       = w_rx_dec;
          bus_in_en[c_DIN] = 1'b1;
          w_state_nxt      = S_T2;
        end else begin
          w_state_nxt = w_after_final;
          if (w_func == c_MVI) begin
            bus_out_en[c_DIN] = 1'b1;
            bus_in_en         = w_rx_dec;
            done              = 1'b1;
          end else if (w_func == c_MV) begin
            bus_out_en = w_ry_dec;
            bus_in_en  = w_rx_dec;
            done       = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      S_T2: begin
        bus_out_en     = w_ry_dec;
        bus_in_en[c_G] = 1'b1;
        alu_sub        = (w_func == c_SUB);
`ifdef XOR_OP_EN
        alu_xor        = (w_func == c_XOR);
`endif
        w_state_nxt    = S_T3;
      end
      S_T3: begin
        bus_out_en[c_G] = 1'b1;
        bus_in_en       = w_rx_dec;
        done            = 1'b1;
        w_state_nxt     = w_after_final;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_proc_ctrl_seq.sv
// Directed table-driven bench for proc_ctrl_seq plus reset-in-flight sequence.
`default_nettype none

module tb_proc_ctrl_seq;

  localparam int RW   = 3;
  localparam int NREG = 8;
  localparam int IW   = 3 + 2*RW;
  localparam int BW   = NREG + 2;
  localparam int EW   = 2*BW + 6;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [IW-1:0] instr = '0;
  logic [BW-1:0] bus_out_en;
  logic [BW-1:0] bus_in_en;
  logic          alu_sub, alu_xor, busy, done, illegal;

  int n_vec  = 0;
  int n_fail = 0;

  proc_ctrl_seq #(.RW(RW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .bus_out_en  (bus_out_en),
    .bus_in_en   (bus_in_en),
    .alu_sub     (alu_sub),
    .alu_xor     (alu_xor),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [IW-1:0] ins;
    logic [EW-1:0] e;
    string         nm;
  } vec_t;

  vec_t tbl[$];

  localparam logic [BW-1:0] DIN = BW'(1) << (NREG + 1);
  localparam logic [BW-1:0] AIN = BW'(1) << (NREG + 1);
  localparam logic [BW-1:0] GB  = BW'(1) << NREG;
  localparam logic [BW-1:0] Z   = '0;

  function automatic logic [BW-1:0] rr(int i);
    return BW'(1) << i;
  endfunction

  function automatic logic [IW-1:0] op(logic [2:0] f, int x, int y);
    return {f, 3'(x), 3'(y)};
  endfunction

  // {ready, out_en, in_en, sub, xor, busy, done, illegal}
  function automatic logic [EW-1:0] ex(logic rd, logic [BW-1:0] oe, logic [BW-1:0] ie,
                                       logic sb, logic xr, logic bs, logic dn, logic il);
    return {rd, oe, ie, sb, xr, bs, dn, il};
  endfunction

  function automatic void addv(logic v, logic [IW-1:0] ins, logic [EW-1:0] e, string nm);
    vec_t t;
    t.valid = v; t.ins = ins; t.e = e; t.nm = nm;
    tbl.push_back(t);
  endfunction

  task automatic check(string nm, logic [EW-1:0] e);
    logic [EW-1:0] act;
    act = {instr_ready, bus_out_en, bus_in_en, alu_sub, alu_xor, busy, done, illegal};
    n_vec++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic check_inv(string nm);
    n_vec++;
    if ($countones(bus_out_en) > 1 || (done && illegal)) begin
      n_fail++;
      $display("FAIL inv_%s: out_en %h done %b illegal %b", nm, bus_out_en, done, illegal);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] idle_e;
    idle_e = ex(1, Z, Z, 0, 0, 0, 0, 0);

    // mvi / add / sub / four mv / add+mv+mvi / illegal + mvi / func 100
    addv(1, op(3'b000, 3, 0), idle_e,                               "idle0");
    addv(0, '0,               ex(1, DIN, rr(3), 0, 0, 1, 1, 0),     "mvi3");
    addv(1, op(3'b010, 1, 2), idle_e,                               "idle1");
    addv(0, '0,               ex(1, rr(1), AIN, 0, 0, 1, 0, 0),     "add_t1");
    addv(0, '0,               ex(1, rr(2), GB, 0, 0, 1, 0, 0),      "add_t2");
    addv(1, op(3'b011, 1, 2), ex(1, GB, rr(1), 0, 0, 1, 1, 0),      "add_t3");
    addv(0, '0,               ex(1, rr(1), AIN, 0, 0, 1, 0, 0),     "sub_t1");
    addv(0, '0,               ex(1, rr(2), GB, 1, 0, 1, 0, 0),      "sub_t2");
    addv(1, op(3'b001, 0, 1), ex(1, GB, rr(1), 0, 0, 1, 1, 0),      "sub_t3");
    addv(1, op(3'b001, 2, 3), ex(1, rr(1), rr(0), 0, 0, 1, 1, 0),   "mv01");
    addv(1, op(3'b001, 4, 5), ex(1, rr(3), rr(2), 0, 0, 1, 1, 0),   "mv23");
    addv(1, op(3'b001, 6, 7), ex(1, rr(5), rr(4), 0, 0, 1, 1, 0),   "mv45");
    addv(1, op(3'b010, 1, 2), ex(1, rr(7), rr(6), 0, 0, 1, 1, 0),   "mv67");
    addv(1, op(3'b001, 3, 4), ex(1, rr(1), AIN, 0, 0, 1, 0, 0),     "bb_add_t1");
    addv(1, op(3'b000, 5, 0), ex(0, rr(2), GB, 0, 0, 1, 0, 0),      "bb_add_t2");
    addv(1, op(3'b000, 5, 0), ex(0, GB, rr(1), 0, 0, 1, 1, 0),      "bb_add_t3");
    addv(1, op(3'b000, 5, 0), ex(1, rr(4), rr(3), 0, 0, 1, 1, 0),   "bb_mv34");
    addv(1, op(3'b111, 0, 0), ex(1, DIN, rr(5), 0, 0, 1, 1, 0),     "bb_mvi5");
    addv(1, op(3'b000, 2, 0), ex(1, Z, Z, 0, 0, 1, 0, 1),           "illegal7");
    addv(0, '0,               ex(1, DIN, rr(2), 0, 0, 1, 1, 0),     "mvi2");
    addv(1, op(3'b100, 1, 2), idle_e,                               "idle2");
`ifdef XOR_OP_EN
    addv(0, '0,               ex(1, rr(1), AIN, 0, 0, 1, 0, 0),     "xor_t1");
    addv(0, '0,               ex(1, rr(2), GB, 0, 1, 1, 0, 0),      "xor_t2");
    addv(0, '0,               ex(1, GB, rr(1), 0, 0, 1, 1, 0),      "xor_t3");
`else
    addv(0, '0,               ex(1, Z, Z, 0, 0, 1, 0, 1),           "f100_illegal");
`endif
    addv(0, '0,               idle_e,                               "idle3");

    resetn = 1'b0;
    @(negedge clk);
    check("reset", idle_e);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check(tbl[i].nm, tbl[i].e);
      check_inv(tbl[i].nm);
      instr_valid = tbl[i].valid;
      instr       = tbl[i].ins;
    end

    // Reset during T2 of sub with an mv pending: everything discarded.
    @(negedge clk);
    check("pre_rst_idle", idle_e);
    instr_valid = 1'b1; instr = op(3'b011, 1, 2);
    @(negedge clk);
    check("rs_sub_t1", ex(1, rr(1), AIN, 0, 0, 1, 0, 0));
    instr = op(3'b001, 3, 4);
    @(negedge clk);
    check("rs_sub_t2", ex(0, rr(2), GB, 1, 0, 1, 0, 0));
    instr_valid = 1'b0; instr = '0;
    #2 resetn = 1'b0;
    #1 check("rst_async", idle_e);
    @(negedge clk);
    check("rst_hold", idle_e);
    resetn = 1'b1;
    @(negedge clk);
    check("no_pend_after_rst", idle_e);
    instr_valid = 1'b1; instr = op(3'b001, 0, 5);
    @(negedge clk);
    check("mv05", ex(1, rr(5), rr(0), 0, 0, 1, 1, 0));
    instr_valid = 1'b0; instr = '0;
    @(negedge clk);
    check("final_idle", idle_e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
